// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_send transmitter among four byte
// producers. uart_send has no busy output, so each frame is timed here by a
// slot counter and the next grant is held off until the slot has elapsed.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no frame in flight; arbitrate among pending requests
// SEND  | frame slot running; uart_din frozen, requests ignored
module uart_tx_arbiter #(
    parameter int CLK_FREQ = 50000,
    parameter int UART_BPS = 9600,
    parameter int EN_HIGH  = 4,
    parameter int GUARD    = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  req,
    input  logic [31:0] din,
    output logic [3:0]  ack,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        uart_en,
    output logic [7:0]  uart_din
);

    localparam int BPS_CNT      = CLK_FREQ / UART_BPS;
    localparam int FRAME_CYCLES = 10 * BPS_CNT + GUARD;

    localparam logic [15:0] SLOT_LAST = 16'(FRAME_CYCLES - 1);
    localparam logic [15:0] EN_CYCLES = 16'(EN_HIGH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]  state;
    logic [1:0]  last_grant;
    logic [15:0] slot_cnt;
    logic [15:0] slot_nxt;
    logic [1:0]  winner;
    logic [1:0]  cand;

    assign slot_nxt = slot_cnt + 16'd1;

    // Pick the first pending requester after last_grant, wrapping; scanning
    // from the farthest offset down lets the nearest one overwrite.
    always_comb begin
        winner = last_grant + 2'd1;
        cand   = '0;
        for (int k = 4; k >= 1; k--) begin
            cand = last_grant + 2'(k);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    // Grant/slot sequencing; ack is a registered single-cycle pulse.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            ack        <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            uart_en    <= 1'b0;
            uart_din   <= '0;
            last_grant <= 2'd3;
            slot_cnt   <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (req != 4'b0000) begin
                        state      <= SEND;
                        busy       <= 1'b1;
                        uart_en    <= 1'b1;
                        uart_din   <= din[{winner, 3'b000} +: 8];
                        grant_id   <= winner;
                        ack        <= 4'b0001 << winner;
                        last_grant <= winner;
                        slot_cnt   <= '0;
                    end
                end
                SEND: begin
                    if (slot_cnt == SLOT_LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        uart_en  <= 1'b0;
                        slot_cnt <= '0;
                    end else begin
                        slot_cnt <= slot_nxt;
                        uart_en  <= (slot_nxt < EN_CYCLES);
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    uart_en  <= 1'b0;
                    slot_cnt <= '0;
                end
            endcase
        end
    end

endmodule
